// File: rtl/sdram_refresh_sched_pkg.sv
// Shared constants for the SDRAM refresh scheduler: FSM state encodings and default tREFI.
package sdram_refresh_sched_pkg;

  localparam int unsigned REFI_CYCLES_DEFAULT = 780;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_REQ        = 2'd1;
  localparam logic [1:0] ST_URGENT     = 2'd2;
  localparam logic [1:0] ST_URGENT_REQ = 2'd3;

  function automatic logic st_is_urgent(input logic [1:0] st);
    return (st == ST_URGENT) || (st == ST_URGENT_REQ);
  endfunction

  function automatic logic st_is_req(input logic [1:0] st);
    return (st == ST_REQ) || (st == ST_URGENT_REQ);
  endfunction

endpackage

// File: rtl/sdram_refresh_sched_refi_timer.sv
// tREFI reload down-counter; emits a one-cycle tick each time it expires while enabled.
module sdram_refi_timer
  import sdram_refresh_sched_pkg::*;
#(
  parameter int unsigned REFI_CYCLES = REFI_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(REFI_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(REFI_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == '0);
    cnt_d = cnt_q;
    if (!en || (cnt_q == '0)) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdram_refresh_sched.sv
// SDRAM auto-refresh scheduler: tracks owed refreshes, issues them lazily, drains them urgently.
// Optional refresh statistics counter enabled by defining SDRAM_REFRESH_STATS_EN.
module sdram_refresh_sched
  import sdram_refresh_sched_pkg::*;
#(
  parameter int unsigned REFI_CYCLES   = REFI_CYCLES_DEFAULT,
  parameter int unsigned MAX_POSTPONE  = 8,
  parameter int unsigned URGENT_THRESH = 6
) (
  input  logic                              sdram_clk,
  input  logic                              sdram_rst_n,
  input  logic                              en_i,
  input  logic                              sdram_idle_i,
  input  logic                              acc_i,
  output logic                              hold_o,
  output logic                              ref_req_o,
  input  logic                              ref_ack_i,
  output logic [$clog2(MAX_POSTPONE+1)-1:0] pending_o,
  output logic                              urgent_o,
  output logic                              overflow_o,
  output logic [15:0]                       ref_count_o
);

  localparam int unsigned PW = $clog2(MAX_POSTPONE + 1);
  localparam logic [PW-1:0] MAX_P = PW'(MAX_POSTPONE);
  localparam logic [PW-1:0] THR   = PW'(URGENT_THRESH);

  logic          tick;
  logic          ack_ok;
  logic [PW-1:0] pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    state_q, state_d;
  logic          ref_req_q, hold_q;

  sdram_refi_timer #(.REFI_CYCLES(REFI_CYCLES)) u_timer (
    .clk   (sdram_clk),
    .rst_n (sdram_rst_n),
    .en    (en_i),
    .tick  (tick)
  );

  assign ack_ok = ref_ack_i && ref_req_q && (pending_q != '0);

  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (!en_i) begin
      pending_d = '0;
    end else begin
      if (tick && !ack_ok && (pending_q != MAX_P)) begin
        pending_d = pending_q + PW'(1);
      end else if (!tick && ack_ok) begin
        pending_d = pending_q - PW'(1);
      end
      if (tick && (pending_q == MAX_P)) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Decisions look at pending_q; only the drain exit uses the post-ack value.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pending_q >= THR) begin
            state_d = ST_URGENT;
          end else if ((pending_q != '0) && sdram_idle_i && !acc_i) begin
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_ok) begin
            state_d = ST_IDLE;
          end else if (pending_q >= THR) begin
            state_d = ST_URGENT_REQ;
          end
        end
        ST_URGENT: begin
          if (sdram_idle_i) begin
            state_d = ST_URGENT_REQ;
          end
        end
        default: begin
          if (ack_ok && (pending_d == '0)) begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      ref_req_q  <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      ref_req_q  <= st_is_req(state_d);
      hold_q     <= st_is_urgent(state_d);
    end
  end

  assign ref_req_o  = ref_req_q;
  assign hold_o     = hold_q;
  assign urgent_o   = hold_q;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

`ifdef SDRAM_REFRESH_STATS_EN
  logic [15:0] ref_count_q;

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      ref_count_q <= '0;
    end else if (ack_ok) begin
      ref_count_q <= ref_count_q + 16'd1;
    end
  end

  assign ref_count_o = ref_count_q;
`else
  assign ref_count_o = '0;
`endif

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Self-checking bench for sdram_refresh_sched: directed scenarios plus randomized traffic vs. a rule model.
module tb_sdram_refresh_sched;

  localparam int REFI = 16;
  localparam int MAXP = 4;
  localparam int THR  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, idle = 1'b0, acc = 1'b0, ack = 1'b0;
  logic        hold, req, urgent, ovf;
  logic [2:0]  pending;
  logic [15:0] rcount;

  int checks = 0;
  int failures = 0;

  sdram_refresh_sched #(.REFI_CYCLES(REFI), .MAX_POSTPONE(MAXP), .URGENT_THRESH(THR)) dut (
    .sdram_clk    (clk),
    .sdram_rst_n  (rst_n),
    .en_i         (en),
    .sdram_idle_i (idle),
    .acc_i        (acc),
    .hold_o       (hold),
    .ref_req_o    (req),
    .ref_ack_i    (ack),
    .pending_o    (pending),
    .urgent_o     (urgent),
    .overflow_o   (ovf),
    .ref_count_o  (rcount)
  );

  always #5 clk = ~clk;

  // Behavioural model: cycles since interval start, owed count, and two mode flags.
  int          m_phase = 0;
  int          m_pend = 0;
  bit          m_ovf = 0, m_req = 0, m_urg = 0;
  logic [15:0] m_rc = '0;

  initial begin
    bit tick, took;
    int newp;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_pend = 0; m_ovf = 0; m_req = 0; m_urg = 0; m_rc = '0;
      end else if (!en) begin
        m_phase = 0; m_pend = 0; m_req = 0; m_urg = 0;
      end else begin
        tick    = (m_phase == REFI - 1);
        m_phase = tick ? 0 : m_phase + 1;
        took    = ack && m_req && (m_pend > 0);
        newp    = m_pend + int'(tick) - int'(took);
        if (newp > MAXP) newp = MAXP;
        if (tick && m_pend == MAXP) m_ovf = 1;
        if (!m_urg && !m_req) begin
          if (m_pend >= THR) m_urg = 1;
          else if (m_pend > 0 && idle && !acc) m_req = 1;
        end else if (!m_urg) begin
          if (took) m_req = 0;
          else if (m_pend >= THR) m_urg = 1;
        end else if (!m_req) begin
          if (idle) m_req = 1;
        end else if (took && newp == 0) begin
          m_urg = 0; m_req = 0;
        end
`ifdef SDRAM_REFRESH_STATS_EN
        if (took) m_rc = m_rc + 16'd1;
`endif
        m_pend = newp;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("model_hold", 32'(hold), 32'(m_urg));
      chk("model_urgent", 32'(urgent), 32'(m_urg));
      chk("model_req", 32'(req), 32'(m_req));
      chk("model_pending", 32'(pending), 32'(m_pend));
      chk("model_overflow", 32'(ovf), 32'(m_ovf));
      chk("model_refcount", 32'(rcount), 32'(m_rc));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 0; idle = 0; acc = 0; ack = 0;
    rst_n = 0;
    step(2);
    rst_n = 1;
    step(1);
  endtask

  task automatic pulse_ack();
    ack = 1;
    step(1);
    ack = 0;
  endtask

  int busy_pct;
  int acc_pct;

  initial begin
    do_reset();
    chk("reset_pending", 32'(pending), 0);
    chk("reset_req", 32'(req), 0);

    // Lazy path
    en = 1; idle = 1; acc = 0;
    step(16);
    chk("lazy_pending_tick", 32'(pending), 1);
    chk("lazy_req_not_yet", 32'(req), 0);
    step(1);
    chk("lazy_req", 32'(req), 1);
    pulse_ack();
    chk("lazy_pending_after_ack", 32'(pending), 0);
    chk("lazy_req_after_ack", 32'(req), 0);
    chk("lazy_hold", 32'(hold), 0);
`ifdef SDRAM_REFRESH_STATS_EN
    chk("lazy_refcount", 32'(rcount), 1);
`else
    chk("lazy_refcount", 32'(rcount), 0);
`endif

    // Urgent drain
    do_reset();
    en = 1; idle = 1; acc = 1;
    step(48);
    chk("urg_pending", 32'(pending), 3);
    step(1);
    chk("urg_hold", 32'(hold), 1);
    chk("urg_urgent", 32'(urgent), 1);
    step(1);
    chk("urg_req", 32'(req), 1);
    pulse_ack();
    chk("urg_drain1", 32'(pending), 2);
    chk("urg_hold1", 32'(hold), 1);
    pulse_ack();
    chk("urg_drain2", 32'(pending), 1);
    pulse_ack();
    chk("urg_drain3", 32'(pending), 0);
    chk("urg_hold_released", 32'(hold), 0);
    chk("urg_urgent_released", 32'(urgent), 0);
`ifdef SDRAM_REFRESH_STATS_EN
    chk("urg_refcount", 32'(rcount), 3);
`endif

    // Overflow
    do_reset();
    en = 1; idle = 0; acc = 0;
    step(79);
    chk("ovf_pending_sat", 32'(pending), 4);
    chk("ovf_not_yet", 32'(ovf), 0);
    step(1);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_pending", 32'(pending), 4);
    step(20);
    chk("ovf_sticky", 32'(ovf), 1);

    // Simultaneous tick+ack, spurious ack, then reset mid-request
    do_reset();
    en = 1; idle = 0; acc = 0;
    step(32);
    chk("tk_pending2", 32'(pending), 2);
    idle = 1;
    step(1);
    chk("tk_req", 32'(req), 1);
    step(14);
    ack = 1;
    step(1);
    ack = 0; idle = 0;
    chk("tk_pending_same", 32'(pending), 2);
    pulse_ack();
    chk("spurious_pending", 32'(pending), 2);
    chk("spurious_req", 32'(req), 0);
    idle = 1;
    step(1);
    chk("rst_pre_req", 32'(req), 1);
    #2 rst_n = 0;
    #1;
    chk("rst_req", 32'(req), 0);
    chk("rst_hold", 32'(hold), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_urgent", 32'(urgent), 0);
    chk("rst_overflow", 32'(ovf), 0);
    chk("rst_refcount", 32'(rcount), 0);
    step(1);
    rst_n = 1;
    step(1);

    // Randomized traffic
    busy_pct = 10; acc_pct = 10;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: begin busy_pct = 10; acc_pct = 10; end
          1: begin busy_pct = 50; acc_pct = 50; end
          default: begin busy_pct = 95; acc_pct = 95; end
        endcase
      end
      en   = ($urandom_range(0, 299) != 0);
      idle = ($urandom_range(0, 99) >= busy_pct);
      acc  = ($urandom_range(0, 99) < acc_pct);
      if (req) ack = ($urandom_range(0, 2) == 0);
      else     ack = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 0;
        #2 rst_n = 1;
      end
      step(1);
    end
    ack = 0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
